// File: rtl/instr_prefetch_buffer.sv
// instr_prefetch_buffer: sequential ROM prefetch into a DEPTH-entry FIFO.
// Optional redirect/empty counters when API_PREFETCH_PERF_EN is defined.
`ifndef API_PC_WIDTH
`define API_PC_WIDTH 32
`endif
`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

module instr_prefetch_buffer #(
    parameter int DEPTH = 4,
    parameter int PC_W = `API_PC_WIDTH,
    parameter int DATA_W = `API_DATA_WIDTH,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    rom_en_o,
    output logic [PC_W-1:0]         rom_addr_o,
    input  logic [DATA_W-1:0]       rom_data_i,
    input  logic                    redirect_i,
    input  logic [PC_W-1:0]         redirect_pc_i,
    output logic                    instr_valid_o,
    output logic [DATA_W-1:0]       instr_o,
    output logic [PC_W-1:0]         instr_pc_o,
    input  logic                    instr_ready_i,
    output logic [$clog2(DEPTH):0]  count_o
`ifdef API_PREFETCH_PERF_EN
    ,
    output logic [31:0]             perf_flush_o,
    output logic [31:0]             perf_empty_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        ST_FETCH,
        ST_STALL
    } state_t;

    state_t              state;
    logic [PC_W-1:0]     fetch_pc;
    logic [PC_W-1:0]     inflight_pc;
    logic                inflight;
    logic [AW-1:0]       wr_ptr;
    logic [AW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [DATA_W-1:0]   data_mem [DEPTH];
    logic [PC_W-1:0]     pc_mem [DEPTH];
    logic [DATA_W-1:0]   hold_instr;
    logic [PC_W-1:0]     hold_pc;
    logic                push;
    logic                pop;
    logic [CW-1:0]       credits;

    assign instr_valid_o = (count != '0);
    assign pop           = instr_valid_o && instr_ready_i;
    assign push          = inflight;
    assign credits       = count + CW'(inflight) - CW'(pop);
    assign rom_en_o      = !reset && !redirect_i && (credits < CW'(DEPTH));
    assign rom_addr_o    = fetch_pc;
    assign count_o       = count;

    // Head outputs fall back to the last presented entry while empty
    assign instr_o    = instr_valid_o ? data_mem[rd_ptr] : hold_instr;
    assign instr_pc_o = instr_valid_o ? pc_mem[rd_ptr] : hold_pc;

    always_ff @(posedge clk) begin
        if (!reset && !redirect_i && push) begin
            data_mem[wr_ptr] <= rom_data_i;
            pc_mem[wr_ptr]   <= inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_FETCH;
            fetch_pc    <= RESET_PC;
            inflight_pc <= RESET_PC;
            inflight    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            hold_instr  <= '0;
            hold_pc     <= '0;
        end else begin
            hold_instr <= instr_o;
            hold_pc    <= instr_pc_o;
            if (redirect_i) begin
                state    <= ST_FETCH;
                fetch_pc <= redirect_pc_i & ~PC_W'(3);
                inflight <= 1'b0;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                count    <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                count    <= count + CW'(push) - CW'(pop);
                inflight <= rom_en_o;
                if (rom_en_o) begin
                    fetch_pc    <= fetch_pc + PC_W'(4);
                    inflight_pc <= fetch_pc;
                end
                unique case (state)
                    ST_FETCH: if (credits == CW'(DEPTH)) state <= ST_STALL;
                    ST_STALL: if (pop) state <= ST_FETCH;
                endcase
            end
        end
    end

`ifdef API_PREFETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_flush_o <= '0;
            perf_empty_o <= '0;
        end else begin
            if (redirect_i && (instr_valid_o || inflight) && perf_flush_o != '1)
                perf_flush_o <= perf_flush_o + 32'd1;
            if (!instr_valid_o && instr_ready_i && perf_empty_o != '1)
                perf_empty_o <= perf_empty_o + 32'd1;
        end
    end
`endif

endmodule
